// File: rtl/refill_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | refill_pkg: shared state encoding and line geometry for the refill   |
// | arbiter.                              Revision: 1.0                  |
// +----------------------------------------------------------------------+
package refill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } refill_state_e;

  localparam int DEF_WORD_W     = 32;
  localparam int DEF_LINE_WORDS = 4;

  // Number of byte-address bits that select a byte within one line.
  function automatic int line_off_w(input int word_w, input int line_words);
    return $clog2(line_words * word_w / 8);
  endfunction

  localparam int DEF_LINE_OFF_W = line_off_w(DEF_WORD_W, DEF_LINE_WORDS);

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter: NUM_CH-wide round-robin grant; the search pointer moves  |
// | past the granted channel only when the grant is accepted. Rev: 1.0   |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int NUM_CH = 2,
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] i_req,
  input  logic              i_accept,
  output logic              o_valid,
  output logic [IDX_W-1:0]  o_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  always_comb begin : p_pick
    logic [IDX_W-1:0] cand;
    cand    = '0;
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_CH);
      if (!o_valid && i_req[cand]) begin
        o_valid = 1'b1;
        o_idx   = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (i_accept && o_valid) begin
      ptr_d = (int'(o_idx) == NUM_CH - 1) ? '0 : o_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/line_refill_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | line_refill_arbiter: shares one word-wide memory read port between   |
// | NUM_CH cache refill requesters and assembles whole lines.            |
// | Option macro: REFILL_CRITICAL_WORD_FIRST_EN      Revision: 1.0       |
// +----------------------------------------------------------------------+
module line_refill_arbiter
  import refill_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int NUM_CH     = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_CH-1:0]            i_req,
  input  logic [NUM_CH*32-1:0]         i_addr,
  output logic                         om_rd,
  output logic [31:0]                  om_addr,
  input  logic                         im_rd_valid,
  input  logic [WORD_W-1:0]            im_rd_data,
  output logic [LINE_WORDS*WORD_W-1:0] o_line,
  output logic [NUM_CH-1:0]            o_done
);

  localparam int c_ch_w  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_wi_w  = $clog2(LINE_WORDS);
  localparam int c_wb_w  = $clog2(WORD_W / 8);
  localparam int c_off_w = line_off_w(WORD_W, LINE_WORDS);
  localparam logic [31:0]       c_line_mask = ~((32'd1 << c_off_w) - 32'd1);
  localparam logic [c_wi_w-1:0] c_last_cnt  = c_wi_w'(LINE_WORDS - 1);

  if ((LINE_WORDS < 2) || ((LINE_WORDS & (LINE_WORDS - 1)) != 0)) begin : g_bad_line_words
    $error("LINE_WORDS must be a power of two and at least 2");
  end

  refill_state_e                  state_q, state_d;
  logic [c_ch_w-1:0]              gnt_q, gnt_d;
  logic [31:0]                    base_q, base_d;
  logic [c_wi_w-1:0]              widx_q, widx_d;
  logic [c_wi_w-1:0]              cnt_q, cnt_d;
  logic [LINE_WORDS*WORD_W-1:0]   line_q, line_d;

  logic                           arb_valid;
  logic [c_ch_w-1:0]              arb_idx;
  logic [31:0]                    req_addr;
  logic [c_wi_w-1:0]              first_widx;

  rr_arbiter #(
    .NUM_CH   (NUM_CH)
  ) u_rr_arbiter (
    .clk      (clk),
    .rstn     (rstn),
    .i_req    (i_req),
    .i_accept (state_q == ST_IDLE),
    .o_valid  (arb_valid),
    .o_idx    (arb_idx)
  );

  assign req_addr = i_addr[32*int'(arb_idx) +: 32];

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  // Start at the missed word; the word index wraps naturally at c_wi_w bits.
  assign first_widx = req_addr[c_off_w-1:c_wb_w];
`else
  assign first_widx = '0;
`endif

  assign om_rd   = (state_q == ST_ISSUE);
  assign om_addr = (state_q == ST_ISSUE) ? (base_q + (32'(widx_q) << c_wb_w)) : 32'd0;
  assign o_line  = line_q;

  always_comb begin
    o_done = '0;
    if (state_q == ST_DONE) begin
      o_done[gnt_q] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    base_d  = base_q;
    widx_d  = widx_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_idx;
          base_d  = req_addr & c_line_mask;
          widx_d  = first_widx;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (im_rd_valid) begin
          line_d[int'(widx_q)*WORD_W +: WORD_W] = im_rd_data;
          widx_d = widx_q + c_wi_w'(1);
          if (cnt_q == c_last_cnt) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + c_wi_w'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      base_q  <= '0;
      widx_q  <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      base_q  <= base_d;
      widx_q  <= widx_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_refill_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_line_refill_arbiter: scoreboard bench with a latency-programmable |
// | memory model and a transaction-level refill reference model.         |
// +----------------------------------------------------------------------+
module tb_line_refill_arbiter;

  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int NUM_CH     = 2;
  localparam int LW         = LINE_WORDS * WORD_W;
  localparam int LINE_BYTES = LINE_WORDS * WORD_W / 8;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b1;
  logic [NUM_CH-1:0]    i_req = '0;
  logic [NUM_CH*32-1:0] i_addr = '0;
  logic                 om_rd;
  logic [31:0]          om_addr;
  logic                 im_rd_valid;
  logic [WORD_W-1:0]    im_rd_data;
  logic [LW-1:0]        o_line;
  logic [NUM_CH-1:0]    o_done;

  always #5 clk = ~clk;

  line_refill_arbiter #(
    .WORD_W      (WORD_W),
    .LINE_WORDS  (LINE_WORDS),
    .NUM_CH      (NUM_CH)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .om_rd       (om_rd),
    .om_addr     (om_addr),
    .im_rd_valid (im_rd_valid),
    .im_rd_data  (im_rd_data),
    .o_line      (o_line),
    .o_done      (o_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  // ---------------- memory model ----------------
  logic [31:0] mem_tab [logic [31:0]];
  int          lat = 1;
  bit          spur = 1'b0;
  int          cyc = 0;
  bit          pend = 1'b0;
  int          due = 0;
  logic [31:0] pdata = '0;
  int          resp_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_tab.exists(a)) return mem_tab[a];
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  always @(negedge clk) begin
    im_rd_valid = 1'b0;
    im_rd_data  = 32'hDEAD_BEEF;
    if (spur) begin
      im_rd_valid = 1'b1;
      im_rd_data  = 32'h0BAD_F00D;
    end
    if (pend && cyc == due) begin
      im_rd_valid = 1'b1;
      im_rd_data  = pdata;
      pend        = 1'b0;
      resp_cnt++;
    end
    if (om_rd === 1'b1) begin
      pend  = 1'b1;
      due   = cyc + lat;
      pdata = mem_word(om_addr);
    end
    cyc++;
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [NUM_CH-1:0] done;
    logic [LW-1:0]     line;
  } done_t;

  logic [31:0]   exp_addr_q [$];
  done_t         exp_done_q [$];
  int            rr_ptr = 0;
  logic [LW-1:0] last_line = '0;

  function automatic void expect_fill(input int ch, input logic [31:0] a);
    logic [31:0]   base;
    int            start;
    logic [LW-1:0] line;
    done_t         e;
    base  = a - (a % LINE_BYTES);
    start = CRIT ? int'((a % LINE_BYTES) / (WORD_W / 8)) : 0;
    for (int k = 0; k < LINE_WORDS; k++) begin
      exp_addr_q.push_back(base + 32'(((start + k) % LINE_WORDS) * (WORD_W / 8)));
    end
    line = '0;
    for (int w = 0; w < LINE_WORDS; w++) begin
      line[w*WORD_W +: WORD_W] = mem_word(base + 32'(w * (WORD_W / 8)));
    end
    e.done = NUM_CH'(1) << ch;
    e.line = line;
    exp_done_q.push_back(e);
    last_line = line;
  endfunction

  function automatic int rr_pick(input logic [NUM_CH-1:0] p);
    for (int k = 0; k < NUM_CH; k++) begin
      if (p[(rr_ptr + k) % NUM_CH]) return (rr_ptr + k) % NUM_CH;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : p_monitor
    done_t e;
    if (rstn === 1'b0) begin
      if (om_rd === 1'b1) begin
        if (exp_addr_q.size() == 0) check("om_rd_unexpected", om_rd, 1'b0);
        else check("om_addr", om_addr, exp_addr_q.pop_front());
      end
      if (o_done !== '0) begin
        if (exp_done_q.size() == 0) begin
          check("o_done_unexpected", o_done, '0);
        end else begin
          e = exp_done_q.pop_front();
          check("o_done", o_done, e.done);
          check("o_line", o_line, e.line);
        end
      end
    end
  end

  int first_done_at = 0;

  // early requests are raised together; late ones appear mid-fill
  task automatic run_round(input logic [NUM_CH-1:0] early, input logic [NUM_CH-1:0] late_in,
                           input logic [31:0] a0, input logic [31:0] a1, input int late_delay);
    logic [NUM_CH-1:0] p;
    logic [NUM_CH-1:0] late;
    logic [NUM_CH-1:0] open;
    logic [31:0]       a [NUM_CH];
    int                ch;
    int                budget;
    late = late_in & ~early;
    a[0] = a0;
    a[1] = a1;
    i_addr = {a1, a0};
    p = early;
    ch = rr_pick(p);
    while (ch >= 0) begin
      expect_fill(ch, a[ch]);
      rr_ptr = (ch + 1) % NUM_CH;
      p[ch] = 1'b0;
      p = p | late;
      late = '0;
      ch = rr_pick(p);
    end
    late = late_in & ~early;
    @(negedge clk);
    i_req = early;
    open  = early | late;
    budget = 0;
    first_done_at = 0;
    while (open != '0 && budget < 3000) begin
      @(negedge clk);
      budget++;
      if (budget == late_delay) i_req = i_req | late;
      if (o_done !== '0) begin
        if (first_done_at == 0) first_done_at = budget;
        i_req = i_req & ~o_done;
        open  = open & ~o_done;
      end
    end
    check("round_complete", open, '0);
    i_req = '0;
    @(negedge clk);
    check("addr_queue_drained", exp_addr_q.size(), 0);
    check("done_queue_drained", exp_done_q.size(), 0);
    exp_addr_q.delete();
    exp_done_q.delete();
  endtask

  initial begin : p_watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin : p_main
    int r0;
    int budget;
    logic [NUM_CH-1:0] e;
    logic [NUM_CH-1:0] l;

    repeat (3) @(negedge clk);
    check("rst_om_rd", om_rd, 1'b0);
    check("rst_om_addr", om_addr, 32'h0);
    check("rst_o_done", o_done, '0);
    check("rst_o_line", o_line, '0);
    rstn = 1'b0;
    repeat (2) @(negedge clk);

    // Directed single ch0 fill with fixed memory contents, 1-cycle latency
    mem_tab[32'h10] = 32'h0043_0820;
    mem_tab[32'h14] = 32'hBADA_881E;
    mem_tab[32'h18] = 32'h0000_0020;
    mem_tab[32'h1C] = 32'hAAAA_AAAA;
    lat = 1;
    run_round(2'b01, 2'b00, 32'h0000_0010, 32'h0, 0);
    check("min_fill_cycles", (first_done_at + 1 >= 2 * LINE_WORDS + 2), 1'b1);
    check("directed_line", o_line, {32'hAAAA_AAAA, 32'h0000_0020, 32'hBADA_881E, 32'h0043_0820});

    // ch1 at an address whose missed word is word 3
    run_round(2'b10, 2'b00, 32'h0, 32'h0000_002C, 0);

    // simultaneous requests, twice: grants alternate ch0, ch1, ch0, ch1
    run_round(2'b11, 2'b00, 32'h0000_1004, 32'h0000_2008, 0);
    run_round(2'b11, 2'b00, 32'h0000_3000, 32'h0000_400C, 0);

    // slow memory and a stray return strobe while idle
    lat = 5;
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (2) @(negedge clk);
    check("o_line_hold_spurious", o_line, last_line);
    run_round(2'b01, 2'b00, 32'h0000_0504, 32'h0, 0);

    // reset in the middle of a fill
    lat = 3;
    i_addr = {32'h0, 32'h0000_0100};
    expect_fill(0, 32'h0000_0100);
    @(negedge clk);
    i_req = 2'b01;
    r0 = resp_cnt;
    budget = 0;
    while (resp_cnt < r0 + 2 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("reset_prefill_progress", (resp_cnt >= r0 + 2), 1'b1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    check("midrst_om_rd", om_rd, 1'b0);
    check("midrst_om_addr", om_addr, 32'h0);
    check("midrst_o_done", o_done, '0);
    check("midrst_o_line", o_line, '0);
    i_req = '0;
    exp_addr_q.delete();
    exp_done_q.delete();
    rr_ptr = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    repeat (6) @(negedge clk);
    check("postrst_o_line", o_line, '0);
    lat = 1;
    run_round(2'b10, 2'b00, 32'h0, 32'h0000_0100, 0);
    run_round(2'b11, 2'b00, 32'h0000_0200, 32'h0000_0304, 0);

    // randomized rounds, including requests raised during a fill
    for (int n = 0; n < 24; n++) begin
      lat = $urandom_range(1, 4);
      e = NUM_CH'($urandom_range(1, 3));
      l = NUM_CH'($urandom_range(0, 3));
      run_round(e, l, $urandom(), $urandom(), $urandom_range(1, 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_refill_arbiter.md
LINE_REFILL_ARBITER -- requirements
Module: line_refill_arbiter

Interface
REQ-001 The block SHALL have parameter WORD_W, default 32, meaning the memory word width in bits.
REQ-002 The block SHALL have parameter LINE_WORDS, default 4, meaning the words per cache line; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have parameter NUM_CH, default 2, meaning the count of requesting caches (ch0 = instruction, ch1 = data).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rstn, input, 1 bit: asynchronous, active-high reset (asserted = 1).
REQ-006 The block SHALL have port i_req, input, NUM_CH bits: per-channel miss request, level, held until the matching o_done.
REQ-007 The block SHALL have port i_addr, input, NUM_CH*32 bits: per-channel byte miss address, stable while i_req is high.
REQ-008 The block SHALL have port om_rd, input-to-memory output, 1 bit: memory word read strobe.
REQ-009 The block SHALL have port om_addr, output, 32 bits: word-aligned byte address of the current read.
REQ-010 The block SHALL have port im_rd_valid, input, 1 bit: memory returns one word.
REQ-011 The block SHALL have port im_rd_data, input, WORD_W bits: the returned word.
REQ-012 The block SHALL have port o_line, output, LINE_WORDS*WORD_W bits: the assembled line, with word 0 in the LSBs.
REQ-013 The block SHALL have port o_done, output, NUM_CH bits: one-cycle one-hot pulse; o_line is valid in that cycle.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-015 In IDLE, when any i_req bit is high, the block SHALL grant one channel by round-robin starting after the last granted channel (ch0 first after reset), latch its line base address (addr with low log2(LINE_WORDS*WORD_W/8) bits cleared), and enter ISSUE.
REQ-016 In ISSUE, the block SHALL drive om_rd=1 for exactly one cycle with om_addr = base + word_index*WORD_W/8, then enter WAIT.
REQ-017 In WAIT, on im_rd_valid the block SHALL store im_rd_data into o_line word slot word_index; it SHALL return to ISSUE if words remain, otherwise enter DONE.
REQ-018 In WAIT, im_rd_valid SHALL be accepted in any cycle from the cycle after om_rd onward; wait latency is unbounded.
REQ-019 In DONE, the block SHALL assert o_done[granted] for one cycle and return to IDLE; a request still high in the next cycle SHALL be treated as new.
REQ-020 A line fill SHALL take at least 2*LINE_WORDS+2 cycles from the request to o_done under 1-cycle memory latency.
REQ-021 Requests arriving during a fill SHALL wait and SHALL not be lost.
REQ-022 Simultaneous requests SHALL be served alternately; no channel SHALL wait more than NUM_CH-1 fills.
REQ-023 A request deasserted mid-fill SHALL still complete the fill and pulse o_done, which the requester ignores.
REQ-024 im_rd_valid outside WAIT SHALL be ignored.
REQ-025 o_line SHALL hold its value outside DONE until overwritten by the next fill.

Reset
REQ-026 While rstn=1, the FSM SHALL be in IDLE, with om_rd=0, om_addr=0, o_done=0, o_line=0, and the round-robin pointer set to ch0.
REQ-027 Reset asserted mid-fill SHALL abort the fill immediately without o_done; the in-flight memory word returned after reset SHALL be ignored.

Configuration
REQ-028 The block SHALL support macro REFILL_CRITICAL_WORD_FIRST_EN.
REQ-029 When REFILL_CRITICAL_WORD_FIRST_EN is defined, the fetch SHALL start at the requested word index and increment modulo LINE_WORDS (wrap-around, e.g. 2,3,0,1); each word SHALL still land in its natural slot.
REQ-030 When REFILL_CRITICAL_WORD_FIRST_EN is undefined, the fetch SHALL always run in order 0..LINE_WORDS-1.

Structure
REQ-031 Package refill_pkg SHALL hold the FSM state enum, the default WORD_W/LINE_WORDS constants, and the helper constant for line byte offset width.
REQ-032 Sub-module rr_arbiter (NUM_CH-wide round-robin grant with a pointer update on accept) SHALL be instantiated once.

Verification
REQ-033 The bench SHALL cover: single ch0 request at 0x00000010 with 1-cycle memory returning 0x00430820,0xBADA881E,0x00000020,0xAAAAAAAA -> om_addr 0x10,0x14,0x18,0x1C; o_done=01; o_line={AAAAAAAA,00000020,BADA881E,00430820}.
REQ-034 The bench SHALL cover: ch0 and ch1 requesting in the same cycle, repeated twice -> grants in the order ch0, ch1, ch0, ch1.
REQ-035 The bench SHALL cover: with REFILL_CRITICAL_WORD_FIRST_EN, ch1 at 0x0000002C -> om_addr 0x2C,0x20,0x24,0x28; each word in its natural slot.
REQ-036 The bench SHALL cover: memory latency of 5 cycles, with a spurious im_rd_valid in IDLE -> line correct and no extra o_done.
REQ-037 The bench SHALL cover: rstn pulsed after the second word -> outputs zero; after release, a re-request completes normally.
